// File: rtl/counter_frame_pkg.sv
// Shared types and helpers for the counter snapshot frame transmitter.
package counter_frame_pkg;

  typedef enum logic [2:0] {IDLE, HDR, UP, DN, CSUM} frame_state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  function automatic logic [7:0] frame_csum(input logic [7:0] hdr,
                                            input logic [7:0] up,
                                            input logic [7:0] dn);
    return hdr ^ up ^ dn;
  endfunction

endpackage

// File: rtl/counter_frame_tx_sample_timer.sv
// Free-running period timer; pulses sample on the last count of each period.
module sample_timer #(
  parameter int PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  output logic sample
);

  localparam logic [15:0] LAST = 16'(PERIOD - 1);

  logic [15:0] r_pcnt;

  always_ff @(posedge clk) begin
    if (reset)               r_pcnt <= '0;
    else if (r_pcnt == LAST) r_pcnt <= '0;
    else                     r_pcnt <= r_pcnt + 16'd1;
  end

  assign sample = (r_pcnt == LAST);

endmodule

// File: rtl/counter_frame_tx.sv
// Snapshots the up/down counter pair each period and streams a 4-byte frame.
module counter_frame_tx
  import counter_frame_pkg::*;
#(
  parameter int         PERIOD = 16,
  parameter logic [7:0] HEADER = FRAME_HEADER
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] upcounter,
  input  logic [7:0] downcounter,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       overrun,
  output logic       mismatch,
  output logic [7:0] frame_count
);

  frame_state_t r_state, w_state_nxt;
  logic [7:0]   r_snap_up, r_snap_dn, r_frame_count;
  logic         r_overrun, r_mismatch;
  logic         w_sample, w_hs, w_capture, w_drop, w_done;
  logic [7:0]   w_sum;

  sample_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .sample (w_sample)
  );

  assign w_hs  = (r_state != IDLE) && tx_ready;
  assign w_sum = upcounter + downcounter;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (w_sample) begin
        w_capture   = 1'b1;
        w_state_nxt = HDR;
      end
      HDR: begin
        w_drop = w_sample;
        if (w_hs) w_state_nxt = UP;
      end
      UP: begin
        w_drop = w_sample;
        if (w_hs) w_state_nxt = DN;
      end
      DN: begin
        w_drop = w_sample;
        if (w_hs) w_state_nxt = CSUM;
      end
      CSUM: begin
        // A sample landing on the final handshake chains straight into the next frame.
        if (w_hs) begin
          w_done      = 1'b1;
          w_capture   = w_sample;
          w_state_nxt = w_sample ? HDR : IDLE;
        end else begin
          w_drop = w_sample;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_snap_up     <= '0;
      r_snap_dn     <= '0;
      r_overrun     <= 1'b0;
      r_mismatch    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_snap_up <= upcounter;
        r_snap_dn <= downcounter;
        if (w_sum != 8'h00) r_mismatch <= 1'b1;
      end
      if (w_drop) r_overrun     <= 1'b1;
      if (w_done) r_frame_count <= r_frame_count + 8'd1;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      HDR:     tx_data = HEADER;
      UP:      tx_data = r_snap_up;
      DN:      tx_data = r_snap_dn;
      CSUM:    tx_data = frame_csum(HEADER, r_snap_up, r_snap_dn);
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid    = (r_state != IDLE);
  assign overrun     = r_overrun;
  assign mismatch    = r_mismatch;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_counter_frame_tx.sv
// Drives two instances (PERIOD 16 and 4) and checks the selected one against a frame-queue model.
module tb_counter_frame_tx;

  logic       clk = 1'b0;
  logic       reset, tx_ready;
  logic [7:0] upcounter, downcounter;

  logic [7:0] d16_data, d4_data, d16_fc, d4_fc;
  logic       d16_valid, d4_valid, d16_ovr, d4_ovr, d16_mm, d4_mm;

  always #5 clk = ~clk;

  counter_frame_tx #(.PERIOD(16)) dut16 (
    .clk(clk), .reset(reset), .upcounter(upcounter), .downcounter(downcounter),
    .tx_data(d16_data), .tx_valid(d16_valid), .tx_ready(tx_ready),
    .overrun(d16_ovr), .mismatch(d16_mm), .frame_count(d16_fc)
  );

  counter_frame_tx #(.PERIOD(4)) dut4 (
    .clk(clk), .reset(reset), .upcounter(upcounter), .downcounter(downcounter),
    .tx_data(d4_data), .tx_valid(d4_valid), .tx_ready(tx_ready),
    .overrun(d4_ovr), .mismatch(d4_mm), .frame_count(d4_fc)
  );

  logic       sel;
  logic [7:0] obs_data, obs_fc;
  logic       obs_valid, obs_ovr, obs_mm;
  assign obs_data  = sel ? d4_data  : d16_data;
  assign obs_valid = sel ? d4_valid : d16_valid;
  assign obs_ovr   = sel ? d4_ovr   : d16_ovr;
  assign obs_mm    = sel ? d4_mm    : d16_mm;
  assign obs_fc    = sel ? d4_fc    : d16_fc;

  // Model: the bytes still owed for the current frame, plus sticky flags and a frame total.
  int         per;
  int         cyc;
  logic [7:0] q[$];
  logic [7:0] txlog[$];
  logic       m_ovr, m_mm;
  int         fc;
  int         nchk = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc = 0; m_ovr = 1'b0; m_mm = 1'b0; fc = 0;
  endtask

  task automatic step(input logic rst, input logic [7:0] u, input logic [7:0] d, input logic rdy);
    logic [7:0] s;
    logic [7:0] fc8;
    if (!rst && obs_valid && rdy) txlog.push_back(obs_data);
    reset = rst; upcounter = u; downcounter = d; tx_ready = rdy;
    if (rst) model_reset();
    else begin
      if (q.size() != 0 && rdy) begin
        void'(q.pop_front());
        if (q.size() == 0) fc++;
      end
      if ((cyc % per) == per - 1) begin
        if (q.size() == 0) begin
          q.push_back(8'hA5); q.push_back(u); q.push_back(d);
          q.push_back(8'hA5 ^ u ^ d);
          s = u + d;
          if (s != 8'h00) m_mm = 1'b1;
        end else m_ovr = 1'b1;
      end
      cyc++;
    end
    @(negedge clk);
    fc8 = fc[7:0];
    chk("tx_valid", {7'd0, obs_valid}, {7'd0, q.size() != 0});
    chk("tx_data", obs_data, (q.size() != 0) ? q[0] : 8'h00);
    chk("overrun", {7'd0, obs_ovr}, {7'd0, m_ovr});
    chk("mismatch", {7'd0, obs_mm}, {7'd0, m_mm});
    chk("frame_count", obs_fc, fc8);
  endtask

  initial begin
    logic [7:0] r;
    int         prev, gaps;
    logic       seen;
    sel = 1'b0; per = 16;
    reset = 1'b1; tx_ready = 1'b1; upcounter = 8'h00; downcounter = 8'h00;
    model_reset();
    @(negedge clk);

    // Counters reset alongside the block: first frame carries 0F/F1.
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    for (int k = 0; k < 20; k++) step(0, 8'(k), 8'(-k), 1);
    chk("f1_len", 8'(txlog.size()), 8'd4);
    if (txlog.size() >= 4) begin
      chk("f1_b0", txlog[0], 8'hA5); chk("f1_b1", txlog[1], 8'h0F);
      chk("f1_b2", txlog[2], 8'hF1); chk("f1_b3", txlog[3], 8'h5B);
    end
    chk("f1_mm", {7'd0, obs_mm}, 8'd0);
    chk("f1_fc", obs_fc, 8'd1);

    // Stall 40 cycles from the first tx_valid; header held, later samples dropped.
    for (int k = 20; k < 32; k++) step(0, 8'(k), 8'(-k), 1);
    for (int k = 32; k < 72; k++) step(0, 8'(k), 8'(-k), 0);
    chk("stall_ovr", {7'd0, obs_ovr}, 8'd1);
    for (int k = 72; k < 79; k++) step(0, 8'(k), 8'(-k), 1);
    chk("f2_len", 8'(txlog.size()), 8'd8);
    if (txlog.size() >= 8) begin
      chk("f2_b0", txlog[4], 8'hA5); chk("f2_b1", txlog[5], 8'h1F);
      chk("f2_b2", txlog[6], 8'hE1); chk("f2_b3", txlog[7], 8'h5B);
    end

    // Inconsistent pair 3/3, then random traffic; mismatch must stay set.
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    txlog.delete();
    for (int k = 0; k < 20; k++) step(0, 8'h03, 8'h03, 1);
    chk("mm_len", 8'(txlog.size()), 8'd4);
    if (txlog.size() >= 4) begin
      chk("mm_b0", txlog[0], 8'hA5); chk("mm_b1", txlog[1], 8'h03);
      chk("mm_b2", txlog[2], 8'h03); chk("mm_b3", txlog[3], 8'hA5);
    end
    chk("mm_set", {7'd0, obs_mm}, 8'd1);
    for (int k = 0; k < 300; k++) begin
      r = 8'($urandom);
      step(0, r, ($urandom_range(0, 1) != 0) ? 8'(-r) : 8'($urandom), $urandom_range(0, 3) != 0);
    end
    chk("mm_sticky", {7'd0, obs_mm}, 8'd1);

    // PERIOD=4: reset while in DN, then 257 back-to-back frames.
    sel = 1'b1; per = 4;
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    for (int k = 0; k < 40 && q.size() != 2; k++) step(0, 8'(k), 8'(-k), 1);
    step(1, 8'h11, 8'hEF, 1);
    chk("rst_valid", {7'd0, obs_valid}, 8'd0);
    chk("rst_data", obs_data, 8'd0);
    chk("rst_fc", obs_fc, 8'd0);
    gaps = 0; seen = 1'b0;
    for (int k = 0; k < 1200 && fc < 257; k++) begin
      prev = fc;
      r = 8'($urandom);
      step(0, r, 8'(-r), 1);
      if (obs_valid) seen = 1'b1;
      else if (seen) gaps++;
      if (fc != prev) begin
        if (fc == 255) chk("fc_255", obs_fc, 8'hFF);
        if (fc == 256) chk("fc_256", obs_fc, 8'h00);
      end
    end
    chk("fc_257", obs_fc, 8'h01);
    chk("no_gap", 8'(gaps), 8'd0);
    chk("p4_ovr", {7'd0, obs_ovr}, 8'd0);

    // PERIOD=4 with random backpressure exercises CSUM stalls and chained captures.
    step(1, 0, 0, 1);
    for (int k = 0; k < 300; k++) begin
      r = 8'($urandom);
      step(0, r, ($urandom_range(0, 3) != 0) ? 8'(-r) : 8'($urandom), $urandom_range(0, 4) != 0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
